elevador_scheduler: RTL
=======================

// Module: elevador_scheduler
// PURPOSE
//   Call scheduler/sequencer for the elevator car: latches floor calls, picks travel
//   direction (SCAN: keep direction while calls remain ahead), times floor-to-floor
//   travel and door dwell, and reports the current floor. It drives the elevator
//   datapath's floor state and door signal, replacing raw per-floor button inputs.
// PARAMETERS
//   N_FLOORS     4  number of floors, 2..16; floors numbered 0..N_FLOORS-1
//   MOVE_CYCLES  3  clock cycles per one-floor move, >=1
//   DOOR_CYCLES  4  clock cycles the door stays open per stop, >=1
// PORTS
//   clk        in   1                  system clock, rising edge
//   reset      in   1                  synchronous, active-high
//   call       in   N_FLOORS           level call request per floor (bit i = floor i)
//   floor      out  FW=$clog2(N_FLOORS) current car floor (registered)
//   moving_up  out  1                  1 while state==MOVE_UP
//   moving_dn  out  1                  1 while state==MOVE_DN
//   door_open  out  1                  1 while state==DOOR
//   pending    out  N_FLOORS           latched, not-yet-served calls
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, floor=0, pending=0, timer=0, last_dir=UP;
//   all outputs 0. Reset wins over everything on the same edge, including mid-move/door.
// - req = pending | call (combinational). Every edge: pending <= req, except the bit
//   of the stop floor is cleared on DOOR entry; clear wins over a same-cycle call.
// - Calls for the current floor while in DOOR are dropped (no latch, no dwell extend).
// - above = |req[N-1:floor+1]; below = |req[floor-1:0] (empty range = 0).
// - States: IDLE, MOVE_UP, MOVE_DN, DOOR; timer counts down, width fits max(MOVE,DOOR).
//   IDLE:  req[floor] -> DOOR (clear pending[floor], timer=DOOR_CYCLES-1)
//          else above && (last_dir==UP || !below) -> MOVE_UP, last_dir=UP, timer=MOVE_CYCLES-1
//          else below -> MOVE_DN, last_dir=DN, timer=MOVE_CYCLES-1
//          else stay IDLE.
//   MOVE_UP: timer!=0 -> timer-1. timer==0 -> floor+1 on that edge, then evaluated on the
//          new floor f': req[f'] -> DOOR (clear, load dwell); else req above f' ->
//          stay MOVE_UP, reload timer; else -> IDLE.
//   MOVE_DN: mirror of MOVE_UP with floor-1 and req below f'.
//   DOOR:  timer!=0 -> timer-1; timer==0 -> IDLE.
// - Latency: call at idle floor sampled at edge t -> door_open=1 from t for DOOR_CYCLES
//   cycles. Each floor step occupies exactly MOVE_CYCLES cycles in MOVE_x.
// - Floor never wraps: MOVE_UP is never entered/continued at N_FLOORS-1, MOVE_DN never
//   at 0 (guaranteed by above/below being 0 there).
// - Direction reversal always passes through IDLE (one cycle) before moving back.
// - Outputs are registered state decodes; exactly one of moving_up/moving_dn/door_open
//   high outside IDLE.
// TESTING
// 1 reset=1 two cycles with call=4'b1111 -> floor=0, pending=0, all status outputs 0.
// 2 IDLE floor0, call=4'b0001 one cycle -> door_open=1 for exactly 4 cycles, then IDLE,
//   pending=0.
// 3 IDLE floor0, call=4'b1000 pulse -> moving_up 9 cycles, floor 1,2,3 at cycles 3,6,9,
//   then door_open 4 cycles at floor 3, pending[3] cleared.
// 4 Moving up between 1 and 2, call 4'b1001 -> serves 3 first (door), IDLE one cycle,
//   MOVE_DN to 0, door at 0; pending ends 0.
// 5 DOOR at floor 2, call=4'b0100 asserted during dwell -> ignored, dwell still 4
//   cycles, pending stays 0.
// 6 reset pulsed while MOVE_UP between floors 1 and 2 with pending=4'b1000 -> next cycle
//   floor=0, IDLE, pending=0, no further motion.

Source files
------------

// File: rtl/elevador_scheduler.sv
// Elevator call scheduler: latches floor calls, runs a SCAN
// sequencer with timed floor moves and door dwell.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high
//   call       level call request per floor (bit i = floor i)
//   floor      current car floor (registered)
//   moving_up  high while the car is moving up
//   moving_dn  high while the car is moving down
//   door_open  high while the door dwell is running
//   pending    latched calls not yet served
module elevador_scheduler #(
    parameter int N_FLOORS    = 4,
    parameter int MOVE_CYCLES = 3,
    parameter int DOOR_CYCLES = 4,
    localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call,
    output logic [FW-1:0]       floor,
    output logic                moving_up,
    output logic                moving_dn,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending
);

    localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES)
                        ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] T_MOVE = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] T_DOOR = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

    state_t                state, state_nxt;
    logic [FW-1:0]         floor_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic                  last_up, last_up_nxt;
    logic [N_FLOORS-1:0]   req, pending_nxt;
    logic                  stop;
    logic [FW-1:0]         stop_floor;
    logic [FW-1:0]         f_up, f_dn;

    function automatic logic any_above(input logic [N_FLOORS-1:0] r,
                                       input logic [FW-1:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (i > int'(f)) a = a | r[i];
        return a;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] r,
                                       input logic [FW-1:0] f);
        logic b;
        b = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (i < int'(f)) b = b | r[i];
        return b;
    endfunction

    assign req  = pending | call;
    assign f_up = floor + FW'(1);
    assign f_dn = floor - FW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            floor   <= '0;
            timer   <= '0;
            last_up <= 1'b1;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            floor   <= floor_nxt;
            timer   <= timer_nxt;
            last_up <= last_up_nxt;
            pending <= pending_nxt;
        end
    end

    // stop/stop_floor mark the floor whose latched call is
    // cleared: on door entry and for the whole dwell, so calls
    // at the open-door floor are dropped rather than latched.
    always_comb begin
        state_nxt   = state;
        floor_nxt   = floor;
        timer_nxt   = timer;
        last_up_nxt = last_up;
        stop        = 1'b0;
        stop_floor  = floor;
        unique case (state)
            IDLE: begin
                if (req[floor]) begin
                    state_nxt = DOOR;
                    timer_nxt = T_DOOR;
                    stop      = 1'b1;
                end else if (any_above(req, floor) &&
                             (last_up || !any_below(req, floor))) begin
                    state_nxt   = MOVE_UP;
                    last_up_nxt = 1'b1;
                    timer_nxt   = T_MOVE;
                end else if (any_below(req, floor)) begin
                    state_nxt   = MOVE_DN;
                    last_up_nxt = 1'b0;
                    timer_nxt   = T_MOVE;
                end
            end
            MOVE_UP: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    floor_nxt = f_up;
                    if (req[f_up]) begin
                        state_nxt  = DOOR;
                        timer_nxt  = T_DOOR;
                        stop       = 1'b1;
                        stop_floor = f_up;
                    end else if (any_above(req, f_up)) begin
                        timer_nxt = T_MOVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            MOVE_DN: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    floor_nxt = f_dn;
                    if (req[f_dn]) begin
                        state_nxt  = DOOR;
                        timer_nxt  = T_DOOR;
                        stop       = 1'b1;
                        stop_floor = f_dn;
                    end else if (any_below(req, f_dn)) begin
                        timer_nxt = T_MOVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                stop = 1'b1;
                if (timer != '0) timer_nxt = timer - TW'(1);
                else             state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pending_nxt = req;
        if (stop) pending_nxt[stop_floor] = 1'b0;
    end

    always_comb begin
        moving_up = (state == MOVE_UP);
        moving_dn = (state == MOVE_DN);
        door_open = (state == DOOR);
    end

endmodule
